// File: rtl/readout_stream_pkg.sv
// readout_stream_pkg: state encodings and default sizing for the readout streamer
package readout_stream_pkg;
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ACTIVE     = 2'd1;
  localparam logic [1:0] WAIT_VALID = 2'd2;
  localparam logic [1:0] STREAM     = 2'd3;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF    = 50;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/readout_stream.sv
// readout_stream: scans the readout DPRAM after a fill and emits present entries as (index, data) words
module readout_stream
  import readout_stream_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readoutActive,
  input  logic                  readoutValid,
  input  logic                  readoutPresent,
  output logic [ADDR_WIDTH-1:0] readoutAddress,
  input  logic [DATA_WIDTH-1:0] readoutData,
  output logic [ADDR_WIDTH-1:0] packetIndex,
  output logic [DATA_WIDTH-1:0] packetData,
  output logic                  packetValid
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, daddr_q, daddr_d, pindex_q, pindex_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_q, rd_d, pvalid_q, pvalid_d;
  logic                  last, abort, timeout;
  always_comb begin
    last    = addr_q == '1;
    abort   = state_q == STREAM && readoutActive;
    timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = readoutActive ? ACTIVE : IDLE;
      ACTIVE:     state_d = readoutActive ? ACTIVE : WAIT_VALID;
      WAIT_VALID: state_d = readoutValid ? STREAM : readoutActive ? ACTIVE : timeout ? IDLE : WAIT_VALID;
      default:    state_d = abort ? ACTIVE : last ? IDLE : STREAM;
    endcase
    addr_d   = (state_q == STREAM && !abort && !last) ? addr_q + 1'b1 : '0;
    cnt_d    = state_q == WAIT_VALID ? cnt_q + 1'b1 : '0;
    // an abort kills both the read just issued and the word already in flight
    rd_d     = state_q == STREAM && !abort;
    daddr_d  = addr_q;
    pvalid_d = rd_q && readoutPresent && !abort;
    pdata_d  = rd_q ? readoutData : pdata_q;
    pindex_d = rd_q ? daddr_q : pindex_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      daddr_q  <= '0;
      pindex_q <= '0;
      pdata_q  <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      daddr_q  <= daddr_d;
      pindex_q <= pindex_d;
      pdata_q  <= pdata_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      pvalid_q <= pvalid_d;
    end
  end
  assign readoutAddress = addr_q;
  assign packetIndex    = pindex_q;
  assign packetData     = pdata_q;
  assign packetValid    = pvalid_q;
endmodule

// File: tb/tb_readout_stream.sv
// tb_readout_stream: scoreboard bench with a registered-read RAM model behind the streamer
module tb_readout_stream;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic readoutActive = 1'b0;
  logic readoutValid = 1'b0;
  logic readoutPresent;
  logic [AW-1:0] readoutAddress;
  logic [DW-1:0] readoutData = '0;
  logic [AW-1:0] packetIndex;
  logic [DW-1:0] packetData;
  logic packetValid;
  logic [DW-1:0] mem [1 << AW];
  logic [AW+DW-1:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int pulses = 0;

  readout_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .readoutActive(readoutActive), .readoutValid(readoutValid),
    .readoutPresent(readoutPresent), .readoutAddress(readoutAddress), .readoutData(readoutData),
    .packetIndex(packetIndex), .packetData(packetData), .packetValid(packetValid));

  always #5 clk = ~clk;
  always @(posedge clk) readoutData <= mem[readoutAddress];
  assign readoutPresent = readoutData != '0;

  task automatic step();
    logic [AW+DW-1:0] e;
    @(posedge clk);
    #1;
    if (packetValid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_packet got idx=%0h data=%0h expected none", packetIndex, packetData);
      end else begin
        e = exp_q.pop_front();
        if ({packetIndex, packetData} !== e) begin
          failures++;
          $display("FAIL packet_word got idx=%0h data=%0h expected idx=%0h data=%0h",
                   packetIndex, packetData, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back({AW'(i), DW'(32'h800 | i)});
  endtask

  task automatic fill(input int cycles);
    readoutActive = 1'b1;
    repeat (cycles) step();
    readoutActive = 1'b0;
  endtask

  task automatic wait_addr(input int a, input string name);
    int n = 0;
    while (readoutAddress !== AW'(a) && n < 700) begin
      step();
      n++;
    end
    checks++;
    if (readoutAddress !== AW'(a)) begin
      failures++;
      $display("FAIL %s never reached address got=%0h expected=%0h", name, readoutAddress, a);
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing packets got_left=%0d expected=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++;
    if (dut.state_q !== 2'd0 || packetValid !== 1'b0 || readoutAddress !== '0 || packetIndex !== '0 || packetData !== '0) begin
      failures++;
      $display("FAIL reset got state=%0d pv=%b addr=%0h idx=%0h data=%0h expected all 0",
               dut.state_q, packetValid, readoutAddress, packetIndex, packetData);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    pulses = 0;
    readoutValid = 1'b0;
    fill(10);
    repeat (45) begin step(); n++; end
    checks++;
    if (dut.state_q !== 2'd2) begin
      failures++;
      $display("FAIL timeout_early got state=%0d expected=2", dut.state_q);
    end
    while (dut.state_q !== 2'd0 && n < TO + 2) begin step(); n++; end
    checks++;
    if (dut.state_q !== 2'd0) begin
      failures++;
      $display("FAIL timeout_idle got state=%0d expected=0", dut.state_q);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL timeout_pulses got=%0d expected=0", pulses);
    end
  endtask

  task automatic test_stream();
    int n = 0;
    pulses = 0;
    fill(10);
    step();
    readoutValid = 1'b1;
    push_range(32'h20, 32'h5F);
    while (dut.state_q !== 2'd0 && n < (1 << AW) + 4) begin step(); n++; end
    checks++;
    if (dut.state_q !== 2'd0) begin
      failures++;
      $display("FAIL stream_idle got state=%0d after %0d cycles expected=0", dut.state_q, n);
    end
    repeat (3) step();
    checks++;
    if (pulses != 64) begin
      failures++;
      $display("FAIL stream_count got=%0d expected=64", pulses);
    end
    check_empty("stream");
  endtask

  task automatic test_no_restart();
    pulses = 0;
    repeat (30) step();
    checks++;
    if (dut.state_q !== 2'd0 || pulses != 0) begin
      failures++;
      $display("FAIL no_restart got state=%0d pulses=%0d expected state=0 pulses=0", dut.state_q, pulses);
    end
  endtask

  task automatic test_abort();
    pulses = 0;
    readoutValid = 1'b0;
    push_range(32'h20, 32'h2E);
    fill(10);
    step();
    readoutValid = 1'b1;
    wait_addr(32'h30, "abort");
    readoutActive = 1'b1;
    step();
    checks++;
    if (dut.state_q !== 2'd1) begin
      failures++;
      $display("FAIL abort_state got=%0d expected=1", dut.state_q);
    end
    repeat (5) step();
    check_empty("abort_flush");
    checks++;
    if (pulses != 15) begin
      failures++;
      $display("FAIL abort_count got=%0d expected=15", pulses);
    end
    pulses = 0;
    push_range(32'h20, 32'h5F);
    readoutActive = 1'b0;
    repeat ((1 << AW) + 6) step();
    checks++;
    if (pulses != 64 || dut.state_q !== 2'd0) begin
      failures++;
      $display("FAIL abort_restream got pulses=%0d state=%0d expected pulses=64 state=0", pulses, dut.state_q);
    end
    check_empty("abort_restream");
  endtask

  task automatic test_reset_mid();
    pulses = 0;
    readoutValid = 1'b0;
    push_range(32'h20, 32'h3E);
    fill(10);
    step();
    readoutValid = 1'b1;
    wait_addr(32'h40, "reset_mid");
    reset = 1'b0;
    step();
    checks++;
    if (packetValid !== 1'b0 || dut.state_q !== 2'd0 || readoutAddress !== '0 || packetIndex !== '0) begin
      failures++;
      $display("FAIL reset_mid got pv=%b state=%0d addr=%0h idx=%0h expected 0", packetValid, dut.state_q, readoutAddress, packetIndex);
    end
    reset = 1'b1;
    repeat (10) step();
    checks++;
    if (pulses != 31 || dut.state_q !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_residual got pulses=%0d state=%0d expected pulses=31 state=0", pulses, dut.state_q);
    end
    check_empty("reset_mid");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = (i >= 32'h20 && i <= 32'h5F) ? DW'(32'h800 | i) : '0;
    test_reset();
    test_timeout();
    test_stream();
    test_no_restart();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
